// File: rtl/uart_receiver.sv
// UART receiver, one bit per i_u_clk cycle: resynchronises rx, deframes start/data/parity/stop
// and presents each word on a valid/ready handshake with per-frame error and overrun flags.
module uart_receiver #(
    parameter int unsigned P_UART_DATA_WIDTH = 8,
    parameter int unsigned P_UART_STOP_WIDTH = 1,
    parameter int unsigned P_UART_CHECK      = 0
) (
    input  logic                         i_u_clk,
    input  logic                         i_u_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data,
    output logic                         o_uart_rx_valid,
    input  logic                         i_uart_rx_ready,
    output logic                         o_uart_rx_check_err,
    output logic                         o_uart_rx_frame_err,
    output logic                         o_uart_rx_overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;

    localparam logic [3:0] L_LAST_DATA = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0] L_LAST_STOP = 4'(P_UART_STOP_WIDTH - 1);

    logic                         r_sync;
    logic                         r_rx_s;
    logic [2:0]                   r_state;
    logic [3:0]                   r_cnt;
    logic [P_UART_DATA_WIDTH-1:0] r_shift;
    logic                         r_acc;
    logic                         r_check_err;
    logic                         r_frame_err;

    logic [P_UART_DATA_WIDTH-1:0] r_rx_data;
    logic                         r_rx_valid;
    logic                         r_rx_check_err;
    logic                         r_rx_frame_err;
    logic                         r_rx_overrun;

    logic [2:0]                   w_state_nxt;
    logic [3:0]                   w_cnt_nxt;
    logic [P_UART_DATA_WIDTH-1:0] w_shift_nxt;
    logic                         w_acc_nxt;
    logic                         w_check_err_nxt;
    logic                         w_frame_err_nxt;
    logic                         w_done;
    logic                         w_accept;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_sync <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_sync <= i_uart_rx;
            r_rx_s <= r_sync;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_acc_nxt       = r_acc;
        w_check_err_nxt = r_check_err;
        w_frame_err_nxt = r_frame_err;
        w_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt     = S_DATA;
                    w_cnt_nxt       = 4'd0;
                    w_acc_nxt       = 1'b0;
                    w_check_err_nxt = 1'b0;
                    w_frame_err_nxt = 1'b0;
                end
            end
            S_DATA: begin
                w_shift_nxt = {r_rx_s, r_shift[P_UART_DATA_WIDTH-1:1]};
                w_acc_nxt   = r_acc ^ r_rx_s;
                if (r_cnt == L_LAST_DATA) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = (P_UART_CHECK != 0) ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_PARITY: begin
                // r_acc is the XOR of the data bits; odd expects ~acc, even expects acc.
                if (P_UART_CHECK == 1) begin
                    w_check_err_nxt = (r_rx_s == r_acc);
                end else begin
                    w_check_err_nxt = (r_rx_s != r_acc);
                end
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                w_frame_err_nxt = r_frame_err | ~r_rx_s;
                if (r_cnt == L_LAST_STOP) begin
                    w_done      = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = w_frame_err_nxt ? S_BREAK : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= '0;
            r_acc       <= 1'b0;
            r_check_err <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_acc       <= w_acc_nxt;
            r_check_err <= w_check_err_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign w_accept = r_rx_valid & i_uart_rx_ready;

    // A completion always wins over a handshake; it only flags overrun if the old word was unread.
    always_ff @(posedge i_u_clk or posedge i_u_rst) begin
        if (i_u_rst) begin
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_check_err <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
        end else if (w_done) begin
            r_rx_data      <= r_shift;
            r_rx_valid     <= 1'b1;
            r_rx_check_err <= r_check_err;
            r_rx_frame_err <= w_frame_err_nxt;
            if (r_rx_valid && !i_uart_rx_ready) begin
                r_rx_overrun <= 1'b1;
            end else if (w_accept) begin
                r_rx_overrun <= 1'b0;
            end
        end else if (w_accept) begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end
    end

    assign o_uart_rx_data      = r_rx_data;
    assign o_uart_rx_valid     = r_rx_valid;
    assign o_uart_rx_check_err = r_rx_check_err;
    assign o_uart_rx_frame_err = r_rx_frame_err;
    assign o_uart_rx_overrun   = r_rx_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: three configurations (none/1 stop, even/2 stops, odd/1 stop) checked
// every cycle against a frame-level model of completions and the output handshake.
module tb_uart_receiver;

    localparam int NI = 3;

    typedef struct {
        int         k;
        longint     t;
        logic [7:0] d;
        logic       ce;
        logic       fe;
    } comp_t;

    logic              clk;
    logic              rst;
    logic [NI-1:0]     rx;
    logic [NI-1:0]     ready;
    logic [NI-1:0][7:0] rdata;
    logic [NI-1:0]     rvalid;
    logic [NI-1:0]     rchk;
    logic [NI-1:0]     rfrm;
    logic [NI-1:0]     rovr;

    logic [NI-1:0][7:0] m_data;
    logic [NI-1:0]     m_valid;
    logic [NI-1:0]     m_chk;
    logic [NI-1:0]     m_frm;
    logic [NI-1:0]     m_ovr;

    comp_t  pend[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    logic   rand_ready = 1'b0;

    uart_receiver #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_dut0 (
        .i_u_clk(clk), .i_u_rst(rst), .i_uart_rx(rx[0]), .o_uart_rx_data(rdata[0]),
        .o_uart_rx_valid(rvalid[0]), .i_uart_rx_ready(ready[0]), .o_uart_rx_check_err(rchk[0]),
        .o_uart_rx_frame_err(rfrm[0]), .o_uart_rx_overrun(rovr[0])
    );
    uart_receiver #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) u_dut1 (
        .i_u_clk(clk), .i_u_rst(rst), .i_uart_rx(rx[1]), .o_uart_rx_data(rdata[1]),
        .o_uart_rx_valid(rvalid[1]), .i_uart_rx_ready(ready[1]), .o_uart_rx_check_err(rchk[1]),
        .o_uart_rx_frame_err(rfrm[1]), .o_uart_rx_overrun(rovr[1])
    );
    uart_receiver #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_dut2 (
        .i_u_clk(clk), .i_u_rst(rst), .i_uart_rx(rx[2]), .o_uart_rx_data(rdata[2]),
        .o_uart_rx_valid(rvalid[2]), .i_uart_rx_ready(ready[2]), .o_uart_rx_check_err(rchk[2]),
        .o_uart_rx_frame_err(rfrm[2]), .o_uart_rx_overrun(rovr[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cfg_check(input int k);
        case (k)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_stop(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_data  = '0;
        m_valid = '0;
        m_chk   = '0;
        m_frm   = '0;
        m_ovr   = '0;
        pend.delete();
    endtask

    // Output-side model: apply any completion due at this edge, else retire an accepted word.
    task automatic model_step();
        comp_t         keep[$];
        comp_t         c[NI];
        logic [NI-1:0] hit;
        logic          hs;
        hit = '0;
        foreach (pend[i]) begin
            if (pend[i].t == cyc) begin
                hit[pend[i].k] = 1'b1;
                c[pend[i].k]   = pend[i];
            end else begin
                keep.push_back(pend[i]);
            end
        end
        pend = keep;
        for (int k = 0; k < NI; k++) begin
            hs = m_valid[k] & ready[k];
            if (hit[k]) begin
                if (m_valid[k] && !ready[k]) m_ovr[k] = 1'b1;
                else if (hs) m_ovr[k] = 1'b0;
                m_data[k]  = c[k].d;
                m_chk[k]   = c[k].ce;
                m_frm[k]   = c[k].fe;
                m_valid[k] = 1'b1;
            end else if (hs) begin
                m_valid[k] = 1'b0;
                m_ovr[k]   = 1'b0;
            end
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check_eq($sformatf("valid%0d", k), 32'(rvalid[k]), 32'(m_valid[k]));
                check_eq($sformatf("overrun%0d", k), 32'(rovr[k]), 32'(m_ovr[k]));
                if (m_valid[k]) begin
                    check_eq($sformatf("data%0d", k), 32'(rdata[k]), 32'(m_data[k]));
                    check_eq($sformatf("check_err%0d", k), 32'(rchk[k]), 32'(m_chk[k]));
                    check_eq($sformatf("frame_err%0d", k), 32'(rfrm[k]), 32'(m_frm[k]));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                for (int k = 0; k < NI; k++) ready[k] = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic drive_bit(input int k, input logic b, output longint t);
        @(posedge clk);
        #1;
        rx[k] = b;
        t = cyc;
    endtask

    task automatic idle(input int k, input int n);
        longint t;
        for (int i = 0; i < n; i++) drive_bit(k, 1'b1, t);
    endtask

    // stops[0] is the first stop bit on the line. Expected outcome is derived from the frame alone.
    task automatic send_frame(input int k, input logic [7:0] d, input logic par,
                              input logic [1:0] stops, output logic fe, output longint t_last);
        longint t;
        comp_t  c;
        int     ones;
        drive_bit(k, 1'b0, t);
        for (int i = 0; i < 8; i++) drive_bit(k, d[i], t);
        if (cfg_check(k) != 0) drive_bit(k, par, t);
        for (int i = 0; i < cfg_stop(k); i++) drive_bit(k, stops[i], t);
        ones = $countones(d) + int'(par);
        c.k  = k;
        c.t  = t + 3;
        c.d  = d;
        case (cfg_check(k))
            1:       c.ce = ((ones % 2) == 0);
            2:       c.ce = ((ones % 2) == 1);
            default: c.ce = 1'b0;
        endcase
        c.fe = (cfg_stop(k) == 2) ? ~&stops : ~stops[0];
        pend.push_back(c);
        fe     = c.fe;
        t_last = t;
    endtask

    task automatic check_word_at(input string tag, input int k, input logic [7:0] d,
                                 input logic ce, input logic fe, input logic ovr);
        repeat (4) @(negedge clk);
        check_eq({tag, "_valid"}, 32'(rvalid[k]), 32'd1);
        check_eq({tag, "_data"}, 32'(rdata[k]), 32'(d));
        check_eq({tag, "_check_err"}, 32'(rchk[k]), 32'(ce));
        check_eq({tag, "_frame_err"}, 32'(rfrm[k]), 32'(fe));
        check_eq({tag, "_overrun"}, 32'(rovr[k]), 32'(ovr));
    endtask

    task automatic run_random(input int k, input int n);
        logic   fe;
        longint t;
        int     gap;
        logic   s0;
        logic   s1;
        fe = 1'b0;
        for (int f = 0; f < n; f++) begin
            gap = $urandom_range(0, 2);
            // After a framing error the line must return high before a new start is seen.
            if (fe && gap == 0) gap = 1;
            idle(k, gap);
            s0 = ($urandom_range(0, 7) != 0);
            s1 = ($urandom_range(0, 7) != 0);
            send_frame(k, 8'($urandom), 1'($urandom), {s1, s0}, fe, t);
        end
        idle(k, 2);
    endtask

    initial begin
        logic       fe;
        longint     t;
        logic [7:0] d;
        logic       p;
        int         n_v;

        rst   = 1'b1;
        rx    = '1;
        ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_eq("rst_valid", 32'(rvalid[k]), 32'd0);
            check_eq("rst_data", 32'(rdata[k]), 32'd0);
            check_eq("rst_check_err", 32'(rchk[k]), 32'd0);
            check_eq("rst_frame_err", 32'(rfrm[k]), 32'd0);
            check_eq("rst_overrun", 32'(rovr[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic 0xA5 frame with exact latency and single-cycle valid.
        ready = '1;
        idle(0, 2);
        send_frame(0, 8'hA5, 1'b0, 2'b11, fe, t);
        repeat (2) @(negedge clk);
        @(negedge clk);
        check_eq("t1_early", 32'(rvalid[0]), 32'd0);
        @(negedge clk);
        check_eq("t1_valid", 32'(rvalid[0]), 32'd1);
        check_eq("t1_data", 32'(rdata[0]), 32'hA5);
        check_eq("t1_errs", 32'({rchk[0], rfrm[0]}), 32'd0);
        @(negedge clk);
        check_eq("t1_one_cycle", 32'(rvalid[0]), 32'd0);

        // Parity: 0x3C with parity bit 0 is good for even, bad for odd.
        send_frame(2, 8'h3C, 1'b0, 2'b11, fe, t);
        check_word_at("t2_odd", 2, 8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(1, 8'h3C, 1'b0, 2'b11, fe, t);
        check_word_at("t2_even", 1, 8'h3C, 1'b0, 1'b0, 1'b0);

        // Second stop bit low then a held-low line: one errored frame only.
        d = 8'h5B;
        p = ^d;
        send_frame(1, d, p, 2'b01, fe, t);
        check_word_at("t3_frame", 1, d, 1'b0, 1'b1, 1'b0);
        n_v = 0;
        for (int i = 0; i < 17; i++) begin
            drive_bit(1, 1'b0, t);
            @(negedge clk);
            if (rvalid[1]) n_v++;
        end
        check_eq("t3_no_repeat", 32'(n_v), 32'd0);
        idle(1, 3);
        d = 8'hC3;
        p = ^d;
        send_frame(1, d, p, 2'b11, fe, t);
        check_word_at("t3_recover", 1, d, 1'b0, 1'b0, 1'b0);

        // Overrun from back-to-back frames with ready low, cleared by a handshake.
        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, fe, t);
        send_frame(0, 8'h22, 1'b0, 2'b11, fe, t);
        check_word_at("t4", 0, 8'h22, 1'b0, 1'b0, 1'b1);
        ready[0] = 1'b1;
        @(negedge clk);
        check_eq("t4_accept_valid", 32'(rvalid[0]), 32'd0);
        check_eq("t4_accept_overrun", 32'(rovr[0]), 32'd0);

        // Handshake on the very edge a new word completes.
        ready[0] = 1'b0;
        send_frame(0, 8'h33, 1'b0, 2'b11, fe, t);
        idle(0, 1);
        send_frame(0, 8'h44, 1'b0, 2'b11, fe, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ready[0] = 1'b1;
        @(posedge clk);
        #1;
        ready[0] = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", 32'(rvalid[0]), 32'd1);
        check_eq("t6_data", 32'(rdata[0]), 32'h44);
        check_eq("t6_overrun", 32'(rovr[0]), 32'd0);
        ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t6_drained", 32'(rvalid[0]), 32'd0);

        // Reset while data bit 4 is being sampled, with an unread word on the outputs.
        ready[0] = 1'b0;
        send_frame(0, 8'h77, 1'b0, 2'b11, fe, t);
        repeat (4) @(negedge clk);
        d = 8'h99;
        drive_bit(0, 1'b0, t);
        for (int i = 0; i < 5; i++) drive_bit(0, d[i], t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        rx[0] = 1'b1;
        #1;
        check_eq("t5_rst_valid", 32'(rvalid[0]), 32'd0);
        check_eq("t5_rst_data", 32'(rdata[0]), 32'd0);
        check_eq("t5_rst_flags", 32'({rchk[0], rfrm[0], rovr[0]}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready[0] = 1'b1;
        idle(0, 2);
        send_frame(0, 8'h5A, 1'b0, 2'b11, fe, t);
        check_word_at("t5_clean", 0, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Randomised traffic on all three configurations at once.
        rand_ready = 1'b1;
        fork
            run_random(0, 30);
            run_random(1, 30);
            run_random(2, 30);
        join
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        ready = '1;
        repeat (8) @(negedge clk);
        check_eq("drain_pending", 32'(pend.size()), 32'd0);
        check_eq("drain_valid", 32'(rvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
